// File: rtl/systolic_mm_engine_if.sv
// Operand-beat stream into, and result-row stream out of, the systolic matrix engine.
interface systolic_mm_engine_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
);
    localparam int IDX_WIDTH = (ROWS > 1) ? $clog2(ROWS) : 1;

    // valid/ready: a transfer happens on every rising clk edge where valid and ready are both
    // high; while valid is high and ready is low the source holds its payload unchanged.
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_row;
    logic [COLS*DATA_WIDTH-1:0] in_col;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS*ACC_WIDTH-1:0]  out_data;
    logic [IDX_WIDTH-1:0]       out_row_idx;
    logic                       out_last;

    modport master (
        output in_valid, in_row, in_col, out_ready,
        input  in_ready, out_valid, out_data, out_row_idx, out_last
    );

    modport slave (
        input  in_valid, in_row, in_col, out_ready,
        output in_ready, out_valid, out_data, out_row_idx, out_last
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS signed MAC array with operand skew, job FSM and row-serial drain.
module systolic_mm_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_MAX      = 256,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    input  logic                       acc_mode,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 fsm_state,
    systolic_mm_engine_if.slave        bus
);
    localparam int KW        = $clog2(K_MAX+1);
    localparam int IW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    cur_state;
    logic [KW-1:0] beat_cnt;
    logic [KW-1:0] k_reg;
    logic [FW-1:0] flush_cnt;
    logic [IW-1:0] row_idx;
    logic          accept;
    logic          clear_acc;

    logic signed [DATA_WIDTH-1:0] feed_a [ROWS];
    logic signed [DATA_WIDTH-1:0] feed_b [COLS];
    logic signed [DATA_WIDTH-1:0] skew_a [ROWS];
    logic signed [DATA_WIDTH-1:0] skew_b [COLS];
    logic signed [ACC_WIDTH-1:0]  acc_w  [ROWS][COLS];

    assign accept        = (cur_state == FEED) && bus.in_valid;
    assign clear_acc     = (cur_state == IDLE) && start && !acc_mode;
    assign bus.in_ready  = (cur_state == FEED);
    assign bus.out_valid = (cur_state == DRAIN);
    assign bus.out_last  = (cur_state == DRAIN) && (row_idx == IW'(ROWS-1));
    assign bus.out_row_idx = row_idx;
    assign busy          = (cur_state != IDLE);
    assign fsm_state     = cur_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= IDLE;
            beat_cnt  <= '0;
            k_reg     <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        beat_cnt  <= '0;
                        row_idx   <= '0;
                        cur_state <= (k_len == '0) ? DRAIN : FEED;
                    end
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt + KW'(1) == k_reg) begin
                            cur_state <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // Long enough for the last beat to cross the array diagonal to PE(ROWS-1,COLS-1).
                    if (flush_cnt == FW'(FLUSH_LEN-1)) cur_state <= DRAIN;
                    else flush_cnt <= flush_cnt + FW'(1);
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (row_idx == IW'(ROWS-1)) begin
                            cur_state <= IDLE;
                            row_idx   <= '0;
                            done      <= 1'b1;
                        end else begin
                            row_idx <= row_idx + IW'(1);
                        end
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

    // Row i of A is delayed i cycles so beat k meets column data of the same k inside PE(i,j).
    for (genvar i = 0; i < ROWS; i++) begin : g_row_skew
        assign feed_a[i] = accept ? bus.in_row[(ROWS-i)*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
        if (i == 0) begin : g_direct
            assign skew_a[i] = feed_a[i];
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] sr [i];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= feed_a[i];
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign skew_a[i] = sr[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col_skew
        assign feed_b[j] = accept ? bus.in_col[(COLS-j)*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
        if (j == 0) begin : g_direct
            assign skew_b[j] = feed_b[j];
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] sr [j];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= feed_b[j];
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign skew_b[j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [DATA_WIDTH-1:0]   a_in;
            logic signed [DATA_WIDTH-1:0]   b_in;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0]    acc;

            if (j == 0) begin : g_a_edge
                assign a_in = skew_a[i];
            end else begin : g_a_chain
                assign a_in = g_row[i].g_col[j-1].g_a_reg.q;
            end
            if (i == 0) begin : g_b_edge
                assign b_in = skew_b[j];
            end else begin : g_b_chain
                assign b_in = g_row[i-1].g_col[j].g_b_reg.q;
            end

            // Pass registers exist only where a neighbour consumes them.
            if (j < COLS-1) begin : g_a_reg
                logic signed [DATA_WIDTH-1:0] q;
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) q <= '0;
                    else       q <= a_in;
                end
            end
            if (i < ROWS-1) begin : g_b_reg
                logic signed [DATA_WIDTH-1:0] q;
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) q <= '0;
                    else       q <= b_in;
                end
            end

            assign prod = a_in * b_in;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)          acc <= '0;
                else if (clear_acc) acc <= '0;
                else                acc <= acc + ACC_WIDTH'(prod);
            end
            assign acc_w[i][j] = acc;
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_out
        assign bus.out_data[(COLS-j)*ACC_WIDTH-1 -: ACC_WIDTH] =
            (cur_state == DRAIN) ? acc_w[row_idx][j] : '0;
    end
endmodule
